// File: rtl/epd_port_arbiter.sv
// Two-port arbiter feeding one packet detector stream: grants one requester at a time,
// forwards its frame with one cycle of latency, enforces MAX_LEN and an inter-frame gap.
module epd_port_arbiter #(
   parameter int unsigned GAP_CYCLES = 2,
   parameter int unsigned MAX_LEN    = 1518
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   input  logic       ctrl0,
   input  logic       ctrl1,
   output logic       gnt0,
   output logic       gnt1,
   output logic [7:0] det_data,
   output logic       det_control,
   output logic       frame_done,
   output logic       done_port,
   output logic       overrun,
   output logic [3:0] frame_cnt0,
   output logic [3:0] frame_cnt1,
   output logic       busy
);

   localparam logic [10:0] MaxLen  = 11'(MAX_LEN);
   localparam logic [3:0]  GapLast = 4'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StGrant, StGap} state_t;

   state_t      state_q, state_d;
   logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic [7:0]  det_data_q, det_data_d;
   logic        det_control_q, det_control_d;
   logic        frame_done_q, frame_done_d;
   logic        overrun_q, overrun_d;
   logic        done_port_q, done_port_d;
   logic [3:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
   logic [10:0] len_q, len_d;
   logic        seen_q, seen_d;
   logic        last_q, last_d;
   logic [3:0]  gap_q, gap_d;
   logic        pick;
   logic        sel_req, sel_ctrl;
   logic [7:0]  sel_data;

   // Only the granted port is observed; gnt1_q identifies it while in StGrant.
   assign sel_req  = gnt1_q ? req1  : req0;
   assign sel_ctrl = gnt1_q ? ctrl1 : ctrl0;
   assign sel_data = gnt1_q ? data1 : data0;

   always_comb begin
      state_d       = state_q;
      gnt0_d        = gnt0_q;
      gnt1_d        = gnt1_q;
      det_data_d    = 8'h00;
      det_control_d = 1'b0;
      frame_done_d  = 1'b0;
      overrun_d     = 1'b0;
      done_port_d   = done_port_q;
      cnt0_d        = cnt0_q;
      cnt1_d        = cnt1_q;
      len_d         = len_q;
      seen_d        = seen_q;
      last_d        = last_q;
      gap_d         = gap_q;
      pick          = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               // On a tie the port that was not served last wins.
               pick    = (req0 && req1) ? ~last_q : req1;
               gnt0_d  = ~pick;
               gnt1_d  = pick;
               last_d  = pick;
               len_d   = 11'd0;
               seen_d  = 1'b0;
               state_d = StGrant;
            end
         end
         StGrant: begin
            if (!seen_q && !sel_req) begin
               gnt0_d  = 1'b0;
               gnt1_d  = 1'b0;
               state_d = StIdle;
            end else if (sel_ctrl) begin
               if (len_q == MaxLen) begin
                  overrun_d   = 1'b1;
                  done_port_d = gnt1_q;
                  gnt0_d      = 1'b0;
                  gnt1_d      = 1'b0;
                  len_d       = 11'd0;
                  seen_d      = 1'b0;
                  gap_d       = 4'd0;
                  state_d     = StGap;
               end else begin
                  det_data_d    = sel_data;
                  det_control_d = 1'b1;
                  len_d         = len_q + 11'd1;
                  seen_d        = 1'b1;
               end
            end else if (seen_q) begin
               frame_done_d = 1'b1;
               done_port_d  = gnt1_q;
               if (gnt1_q) cnt1_d = cnt1_q + 4'd1;
               else        cnt0_d = cnt0_q + 4'd1;
               gnt0_d  = 1'b0;
               gnt1_d  = 1'b0;
               len_d   = 11'd0;
               seen_d  = 1'b0;
               gap_d   = 4'd0;
               state_d = StGap;
            end
         end
         StGap: begin
            if (gap_q == GapLast) state_d = StIdle;
            else                  gap_d   = gap_q + 4'd1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= StIdle;
         gnt0_q        <= 1'b0;
         gnt1_q        <= 1'b0;
         det_data_q    <= 8'h00;
         det_control_q <= 1'b0;
         frame_done_q  <= 1'b0;
         overrun_q     <= 1'b0;
         done_port_q   <= 1'b0;
         cnt0_q        <= 4'd0;
         cnt1_q        <= 4'd0;
         len_q         <= 11'd0;
         seen_q        <= 1'b0;
         last_q        <= 1'b1;
         gap_q         <= 4'd0;
      end else begin
         state_q       <= state_d;
         gnt0_q        <= gnt0_d;
         gnt1_q        <= gnt1_d;
         det_data_q    <= det_data_d;
         det_control_q <= det_control_d;
         frame_done_q  <= frame_done_d;
         overrun_q     <= overrun_d;
         done_port_q   <= done_port_d;
         cnt0_q        <= cnt0_d;
         cnt1_q        <= cnt1_d;
         len_q         <= len_d;
         seen_q        <= seen_d;
         last_q        <= last_d;
         gap_q         <= gap_d;
      end
   end

   assign gnt0        = gnt0_q;
   assign gnt1        = gnt1_q;
   assign det_data    = det_data_q;
   assign det_control = det_control_q;
   assign frame_done  = frame_done_q;
   assign overrun     = overrun_q;
   assign done_port   = done_port_q;
   assign frame_cnt0  = cnt0_q;
   assign frame_cnt1  = cnt1_q;
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_epd_port_arbiter.sv
// Directed bench for epd_port_arbiter: one instance at MAX_LEN=1518, one at MAX_LEN=64.
module tb_epd_port_arbiter;

   logic       clock, reset;
   logic       req0, req1, ctrl0, ctrl1;
   logic [7:0] data0, data1;

   logic       gnt0, gnt1, det_control, frame_done, done_port, overrun, busy;
   logic [7:0] det_data;
   logic [3:0] frame_cnt0, frame_cnt1;

   logic       b_gnt0, b_gnt1, b_det_control, b_frame_done, b_done_port, b_overrun, b_busy;
   logic [7:0] b_det_data;
   logic [3:0] b_frame_cnt0, b_frame_cnt1;

   int total = 0;
   int bad   = 0;
   logic [7:0] frame [72];

   epd_port_arbiter #(.GAP_CYCLES(2), .MAX_LEN(1518)) dut_a (
      .clock(clock), .reset(reset), .req0(req0), .req1(req1),
      .data0(data0), .data1(data1), .ctrl0(ctrl0), .ctrl1(ctrl1),
      .gnt0(gnt0), .gnt1(gnt1), .det_data(det_data), .det_control(det_control),
      .frame_done(frame_done), .done_port(done_port), .overrun(overrun),
      .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1), .busy(busy)
   );

   epd_port_arbiter #(.GAP_CYCLES(2), .MAX_LEN(64)) dut_b (
      .clock(clock), .reset(reset), .req0(req0), .req1(req1),
      .data0(data0), .data1(data1), .ctrl0(ctrl0), .ctrl1(ctrl1),
      .gnt0(b_gnt0), .gnt1(b_gnt1), .det_data(b_det_data), .det_control(b_det_control),
      .frame_done(b_frame_done), .done_port(b_done_port), .overrun(b_overrun),
      .frame_cnt0(b_frame_cnt0), .frame_cnt1(b_frame_cnt1), .busy(b_busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req0 = 1'b0; req1 = 1'b0; ctrl0 = 1'b0; ctrl1 = 1'b0;
      data0 = 8'h00; data1 = 8'h00;
      tick();
      reset = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 7; i++) frame[i] = 8'h55;
      frame[7] = 8'hD5;
      for (int i = 0; i < 6; i++) frame[8 + i] = 8'h10 + 8'(i);
      for (int i = 0; i < 6; i++) frame[14 + i] = 8'h20 + 8'(i);
      frame[20] = 8'h08;
      frame[21] = 8'h00;
      for (int i = 0; i < 50; i++) frame[22 + i] = 8'h80 + 8'(i);

      // Reset state
      do_reset();
      chk("rst_gnt0", gnt0, 0);
      chk("rst_gnt1", gnt1, 0);
      chk("rst_det_control", det_control, 0);
      chk("rst_det_data", det_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done_port", done_port, 0);
      chk("rst_cnt0", frame_cnt0, 0);

      // Single 72-byte frame on port 0
      req0 = 1'b1;
      tick();
      chk("sf_gnt0", gnt0, 1);
      chk("sf_busy", busy, 1);
      chk("sf_det_control_pre", det_control, 0);
      for (int i = 0; i < 72; i++) begin
         ctrl0 = 1'b1; data0 = frame[i];
         tick();
         chk("sf_det_data", det_data, frame[i]);
         chk("sf_det_control", det_control, 1);
      end
      ctrl0 = 1'b0; req0 = 1'b0; data0 = 8'h00;
      tick();
      chk("sf_frame_done", frame_done, 1);
      chk("sf_done_port", done_port, 0);
      chk("sf_cnt0", frame_cnt0, 1);
      chk("sf_gnt0_low", gnt0, 0);
      chk("sf_det_control_end", det_control, 0);
      tick();
      chk("sf_done_pulse", frame_done, 0);
      chk("sf_gap_busy", busy, 1);
      tick();
      chk("sf_idle", busy, 0);

      // Reset in the middle of a port 0 frame
      req0 = 1'b1;
      tick();
      chk("mr_gnt0", gnt0, 1);
      for (int i = 0; i < 30; i++) begin
         ctrl0 = 1'b1; data0 = frame[i];
         tick();
      end
      chk("mr_before_cnt0", frame_cnt0, 1);
      reset = 1'b0; data0 = frame[30];
      tick();
      chk("mr_gnt0", gnt0, 0);
      chk("mr_det_control", det_control, 0);
      chk("mr_det_data", det_data, 0);
      chk("mr_busy", busy, 0);
      chk("mr_cnt0", frame_cnt0, 0);
      chk("mr_frame_done", frame_done, 0);
      reset = 1'b1; ctrl0 = 1'b0; req0 = 1'b0;
      tick();
      tick();
      chk("mr_after_done", frame_done, 0);
      chk("mr_after_cnt0", frame_cnt0, 0);

      // Tie: port 0 first, then port 1 after gap, then port 0 again
      do_reset();
      req0 = 1'b1; req1 = 1'b1; ctrl1 = 1'b1; data1 = 8'hEE;
      tick();
      chk("tie_gnt0", gnt0, 1);
      chk("tie_gnt1", gnt1, 0);
      for (int i = 0; i < 3; i++) begin
         ctrl0 = 1'b1; data0 = 8'hA0 + 8'(i);
         tick();
         chk("tie_p0_data", det_data, 8'hA0 + 8'(i));
      end
      ctrl0 = 1'b0; ctrl1 = 1'b0;
      tick();
      chk("tie_p0_done", frame_done, 1);
      chk("tie_p0_port", done_port, 0);
      tick();
      chk("tie_gap_gnt1", gnt1, 0);
      tick();
      chk("tie_idle_gnt1", gnt1, 0);
      chk("tie_idle_busy", busy, 0);
      tick();
      chk("tie_gnt1", gnt1, 1);
      chk("tie_gnt0_off", gnt0, 0);
      for (int i = 0; i < 2; i++) begin
         ctrl1 = 1'b1; data1 = 8'hB0 + 8'(i);
         tick();
         chk("tie_p1_data", det_data, 8'hB0 + 8'(i));
      end
      ctrl1 = 1'b0;
      tick();
      chk("tie_p1_done", frame_done, 1);
      chk("tie_p1_port", done_port, 1);
      chk("tie_cnt1", frame_cnt1, 1);
      chk("tie_cnt0", frame_cnt0, 1);
      tick();
      tick();
      chk("tie_port_held", done_port, 1);
      tick();
      chk("tie_regrant0", gnt0, 1);
      chk("tie_regrant1", gnt1, 0);

      // Withdrawal of port 1 before ctrl1 rises
      do_reset();
      req1 = 1'b1;
      tick();
      chk("wd_gnt1", gnt1, 1);
      req1 = 1'b0; req0 = 1'b1;
      tick();
      chk("wd_gnt1_low", gnt1, 0);
      chk("wd_gnt0_low", gnt0, 0);
      chk("wd_idle", busy, 0);
      chk("wd_no_done", frame_done, 0);
      tick();
      chk("wd_gnt0", gnt0, 1);

      // Overrun on the MAX_LEN=64 instance, port 1
      do_reset();
      req1 = 1'b1;
      tick();
      chk("ov_gnt1", b_gnt1, 1);
      for (int i = 0; i < 64; i++) begin
         ctrl1 = 1'b1; data1 = 8'(i + 1);
         tick();
         chk("ov_data", b_det_data, 8'(i + 1));
         chk("ov_ctrl", b_det_control, 1);
      end
      data1 = 8'd65;
      tick();
      chk("ov_pulse", b_overrun, 1);
      chk("ov_det_control", b_det_control, 0);
      chk("ov_gnt1_low", b_gnt1, 0);
      chk("ov_done_port", b_done_port, 1);
      chk("ov_cnt1", b_frame_cnt1, 0);
      chk("ov_no_done", b_frame_done, 0);
      req1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         data1 = 8'(66 + i);
         tick();
         chk("ov_drop_ctrl", b_det_control, 0);
         chk("ov_drop_gnt1", b_gnt1, 0);
      end
      chk("ov_pulse_once", b_overrun, 0);
      ctrl1 = 1'b0;

      // Wrap: 16 two-byte frames on port 0
      do_reset();
      for (int k = 0; k < 16; k++) begin
         req0 = 1'b1;
         tick();
         ctrl0 = 1'b1; data0 = 8'h11;
         tick();
         tick();
         ctrl0 = 1'b0; req0 = 1'b0;
         tick();
         if (k == 14) chk("wrap_cnt15", frame_cnt0, 15);
         tick();
         tick();
      end
      chk("wrap_cnt0", frame_cnt0, 0);
      chk("wrap_cnt1", frame_cnt1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
